spi_ram_ctrl: RTL and testbench

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

---
 rtl/spi_ram_pkg.sv | 28 ++
 rtl/spi_ram_ctrl_if.sv | 14 +
 rtl/spi_ram_sp_mem.sv | 26 ++
 rtl/spi_ram_ctrl.sv | 110 +++++++++++
 tb/tb_spi_ram_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and defaults for the SPI-attached RAM controller:
// opcodes, read-side FSM encoding and the command word layout.
package spi_ram_pkg;

  localparam int unsigned MEM_DEPTH_DEF = 256;
  localparam int unsigned ADDR_SIZE_DEF = 8;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned RX_W          = 10;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    R_NOADDR = 2'd0,
    R_READY  = 2'd1,
    R_OUT    = 2'd2
  } rd_state_e;

  typedef struct packed {
    opcode_e           op;
    logic [DATA_W-1:0] payload;
  } cmd_t;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command/response link between the SPI slave front end and the RAM controller.
interface spi_ram_ctrl_if;
  import spi_ram_pkg::*;

  logic [RX_W-1:0]   rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              err;

  modport master (output rx_data, rx_valid, input tx_data, tx_valid, err);
  modport slave  (input rx_data, rx_valid, output tx_data, tx_valid, err);

endinterface

// File: rtl/spi_ram_sp_mem.sv
// Single-port RAM: synchronous write, registered read, one access per cycle.
module spi_ram_sp_mem
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Contents are deliberately not reset so they survive rst_n.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI command words into RAM writes/reads; one command per
// rx_valid rising edge, read data returned two cycles after acceptance.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_ctrl_if.slave  bus
);

  cmd_t                 cmd;
  logic                 rx_valid_q;
  logic                 rx_armed;
  logic                 rx_rise_c;
  logic                 wr_fire_c;
  logic                 rd_fire_c;
  logic [ADDR_SIZE-1:0] mem_addr_c;
  logic [DATA_W-1:0]    mem_rdata;

  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_addr_ok;
  logic                 rd_pend;
  rd_state_e            rd_state;
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_valid;
  logic                 err;

  assign cmd = cmd_t'(bus.rx_data);

  // rx_armed blocks a level that was already high when reset released.
  assign rx_rise_c  = bus.rx_valid & ~rx_valid_q & rx_armed;
  assign wr_fire_c  = rst_n & rx_rise_c & (cmd.op == WR_DATA) & wr_addr_ok;
  assign rd_fire_c  = rst_n & rx_rise_c & (cmd.op == RD_DATA) & (rd_state != R_NOADDR);
  assign mem_addr_c = wr_fire_c ? wr_addr : rd_addr;

  spi_ram_sp_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .en    (wr_fire_c | rd_fire_c),
    .we    (wr_fire_c),
    .addr  (mem_addr_c),
    .wdata (cmd.payload),
    .rdata (mem_rdata)
  );

  // Command decode and read FSM; tx outputs load one cycle after the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_armed   <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_addr_ok <= 1'b0;
      rd_pend    <= 1'b0;
      rd_state   <= R_NOADDR;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      rx_valid_q <= bus.rx_valid;
      rx_armed   <= rx_armed | ~bus.rx_valid;
      rd_pend    <= rd_fire_c;

      if (rd_pend) begin
        tx_data  <= mem_rdata;
        tx_valid <= 1'b1;
      end

      if (rx_rise_c) begin
        unique case (cmd.op)
          WR_ADDR: begin
            wr_addr    <= ADDR_SIZE'(cmd.payload);
            wr_addr_ok <= 1'b1;
            tx_valid   <= 1'b0;
          end
          WR_DATA: begin
            if (wr_addr_ok) wr_addr <= wr_addr + ADDR_SIZE'(1);
            else            err     <= 1'b1;
            tx_valid <= 1'b0;
          end
          RD_ADDR: begin
            rd_addr  <= ADDR_SIZE'(cmd.payload);
            rd_state <= R_READY;
            tx_valid <= 1'b0;
          end
          RD_DATA: begin
            if (rd_state == R_NOADDR) begin
              err      <= 1'b1;
              tx_valid <= 1'b0;
            end else begin
              rd_addr  <= rd_addr + ADDR_SIZE'(1);
              rd_state <= R_OUT;
            end
          end
        endcase
      end
    end
  end

  assign bus.tx_data  = tx_data;
  assign bus.tx_valid = tx_valid;
  assign bus.err      = err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: write/read paths, wrap, level hold,
// reset behaviour and the sticky error flag.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl_if bus();

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Present one command for 'hold' cycles; returns at the negedge after the first accepting edge when hold==1.
  task automatic send(input opcode_e op, input logic [7:0] pl, input int hold);
    @(negedge clk);
    bus.rx_data  = {op, pl};
    bus.rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Issue RD_DATA and sample tx one and two cycles after the rx_valid rise.
  task automatic rd_data(output logic v_e1, output logic v_e2, output logic [7:0] d_e2);
    send(RD_DATA, 8'h00, 1);
    v_e1 = bus.tx_valid;
    @(negedge clk);
    v_e2 = bus.tx_valid;
    d_e2 = bus.tx_data;
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    // rx_valid already high at reset release must not be taken as a command
    bus.rx_data  = {RD_DATA, 8'h00};
    bus.rx_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_release_edge: err got %b expected 0", bus.err); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_release_txv: got %b expected 0", bus.tx_valid); end
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic v1, v2;
    logic [7:0] d;
    send(WR_ADDR, 8'h10, 1);
    send(WR_DATA, 8'hA5, 1);
    send(RD_ADDR, 8'h10, 1);
    rd_data(v1, v2, d);
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL basic_latency_e1: tx_valid got %b expected 0", v1); end
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL basic_latency_e2: tx_valid got %b expected 1", v2); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", d); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_hold_then_cmd();
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL out_hold_valid: got %b expected 1", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL out_hold_data: got %h expected a5", bus.tx_data); end
    send(WR_ADDR, 8'h40, 1);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL wr_addr_drops_txv: got %b expected 0", bus.tx_valid); end
  endtask

  task automatic test_wrap();
    logic v1, v2;
    logic [7:0] d;
    send(WR_ADDR, 8'hFF, 1);
    send(WR_DATA, 8'h11, 1);
    send(WR_DATA, 8'h22, 1);
    send(RD_ADDR, 8'hFF, 1);
    rd_data(v1, v2, d);
    checks++; if (d !== 8'h11 || v2 !== 1'b1) begin errors++; $display("FAIL wrap_rd_ff: got %h/%b expected 11/1", d, v2); end
    rd_data(v1, v2, d);
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL wrap_rd_keep_valid: got %b expected 1", v1); end
    checks++; if (d !== 8'h22 || v2 !== 1'b1) begin errors++; $display("FAIL wrap_rd_00: got %h/%b expected 22/1", d, v2); end
    send(RD_ADDR, 8'h00, 1);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rd_addr_drops_txv: got %b expected 0", bus.tx_valid); end
  endtask

  task automatic test_level_hold();
    logic v1, v2;
    logic [7:0] d;
    send(WR_ADDR, 8'h21, 1);
    send(WR_DATA, 8'h5A, 1);
    send(WR_ADDR, 8'h20, 1);
    send(WR_DATA, 8'h3C, 4);
    send(RD_ADDR, 8'h20, 1);
    rd_data(v1, v2, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL hold_mem20: got %h expected 3c", d); end
    rd_data(v1, v2, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL hold_mem21_unchanged: got %h expected 5a", d); end
    send(WR_DATA, 8'h99, 1);
    send(RD_ADDR, 8'h21, 1);
    rd_data(v1, v2, d);
    checks++; if (d !== 8'h99) begin errors++; $display("FAIL hold_wr_addr_21: got %h expected 99", d); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL hold_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_raw();
    logic v1, v2;
    logic [7:0] d;
    send(RD_ADDR, 8'h50, 1);
    send(WR_ADDR, 8'h50, 1);
    send(WR_DATA, 8'h6E, 1);
    rd_data(v1, v2, d);
    checks++; if (d !== 8'h6E || v2 !== 1'b1) begin errors++; $display("FAIL raw_data: got %h/%b expected 6e/1", d, v2); end
  endtask

  task automatic test_reset_mid();
    logic v1, v2;
    logic [7:0] d;
    send(RD_ADDR, 8'h10, 1);
    rd_data(v1, v2, d);
    checks++; if (v2 !== 1'b1 || d !== 8'hA5) begin errors++; $display("FAIL pre_reset_read: got %h/%b expected a5/1", d, v2); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL async_reset_txv: got %b expected 0", bus.tx_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_tx_data: got %h expected 00", bus.tx_data); end
    // Reset landing between acceptance and tx load must cancel the read
    send(RD_ADDR, 8'h10, 1);
    send(RD_DATA, 8'h00, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL pending_abort_txv: got %b expected 0", bus.tx_valid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mid_reset_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_err_sticky();
    logic v1, v2;
    logic [7:0] d;
    rd_data(v1, v2, d);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL noaddr_err: got %b expected 1", bus.err); end
    checks++; if (v1 !== 1'b0 || v2 !== 1'b0) begin errors++; $display("FAIL noaddr_txv: got %b%b expected 00", v1, v2); end
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL noaddr_tx_data: got %h expected 00", d); end
    send(WR_DATA, 8'h77, 1);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL sticky_after_wr_data: got %b expected 1", bus.err); end
    send(RD_ADDR, 8'h10, 1);
    rd_data(v1, v2, d);
    checks++; if (d !== 8'hA5 || v2 !== 1'b1) begin errors++; $display("FAIL mem_survives_reset: got %h/%b expected a5/1", d, v2); end
    send(RD_ADDR, 8'h00, 1);
    rd_data(v1, v2, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL wr_without_addr_no_write: got %h expected 22", d); end
    send(WR_ADDR, 8'h30, 1);
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL sticky_final: got %b expected 1", bus.err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_then_cmd();
    test_wrap();
    test_level_hold();
    test_raw();
    test_reset_mid();
    test_err_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
